ripple_count_monitor: RTL and testbench

- Synchronous consumer placed directly downstream of the 4-bit ripple counter.
- Captures the counter's asynchronously-settling Q bus into the clk domain and filters out ripple transients.
- Counts 15->0 wraps to extend the count width.
- Raises an armed threshold interrupt with a level/ack handshake, for use by control logic elsewhere in the design.

---
 rtl/ripple_count_monitor.sv | 173 +++++++++++++++++
 tb/tb_ripple_count_monitor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//
// Synchronous consumer of a free-running 4-bit ripple counter. The Q bus
// settles bit by bit, so it is double-registered into the clk domain before
// use. Wraps of the 4-bit value (15 -> 0, or any backwards step) extend the
// count by EXT_W bits. A small IDLE/ARMED/FIRED FSM raises match_irq once the
// extended count reaches a threshold, and holds it until acknowledged.
//
// Build option:
//   RCM_GLITCH_FILTER_EN  defined   -> f only accepts a value once two
//                                      consecutive samples agree (3-edge
//                                      latency, single-cycle transients
//                                      are rejected).
//                         undefined -> f follows the first capture stage on
//                                      every enabled cycle (2-edge latency).

module ripple_count_monitor #(
  parameter  int EXT_W = 4,
  localparam int CW    = EXT_W + 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [3:0]    q_in,
  input  logic          enable,
  input  logic          clr,
  input  logic [CW-1:0] thresh,
  input  logic          arm,
  input  logic          ack,
  output logic [CW-1:0] count_ext,
  output logic          wrap_pulse,
  output logic          ovf,
  output logic          match_irq,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  // Capture stages and filtered low nibble.
  logic [3:0]       s1;
  logic [3:0]       f;
  logic [EXT_W-1:0] ext;

  // Decisions made from pre-edge register values.
  logic f_upd;     // f takes s1 at this edge
  logic wrap_det;  // the value f is about to take is below the current f
  logic count_ge;  // registered extended count has reached thresh

  state_t state_q;
  state_t state_d;

`ifdef RCM_GLITCH_FILTER_EN
  logic [3:0] s2;

  // Second capture stage; only needed for the agreement check.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s2 <= 4'd0;
    end else begin
      s2 <= s1;
    end
  end
`endif

  // First capture stage runs every cycle, regardless of enable.
  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples pre-edge values; blocking here would collapse s1/s2 into one flop.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1 <= 4'd0;
    end else begin
      s1 <= q_in;
    end
  end

  // Decide whether f moves this edge and whether that move is a wrap.
  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    f_upd    = 1'b0;
    wrap_det = 1'b0;
`ifdef RCM_GLITCH_FILTER_EN
    f_upd    = enable && (s1 == s2);
`else
    f_upd    = enable;
`endif
    // A backwards step cannot be told apart from a 15 -> 0 roll, so any
    // decrease of the accepted value is treated as one wrap.
    wrap_det = f_upd && (s1 < f);
  end

  // Filtered low nibble; clr deliberately leaves it alone.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      f <= 4'd0;
    end else if (f_upd) begin
      f <= s1;
    end
  end

  // Extension counter, overflow flag and wrap pulse; clr has priority.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ext        <= '0;
      ovf        <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (clr) begin
        ext <= '0;
        ovf <= 1'b0;
      end else if (wrap_det) begin
        ext        <= ext + 1'b1;
        wrap_pulse <= 1'b1;
        if (&ext) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  // Both halves are registers, so count_ext has no input-to-output path.
  assign count_ext = {ext, f};

  // Threshold compare against the registered count; thresh is not latched.
  always_comb begin
    count_ge = (count_ext >= thresh);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: arm only matters in IDLE, ack only in FIRED.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (count_ge) begin
          state_d = FIRED;
        end
      end
      FIRED: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs are plain decodes of the state register.
  always_comb begin
    match_irq = (state_q == FIRED);
    state     = state_q;
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Self-checking bench for ripple_count_monitor.
// A reference model steps once per rising edge from the pre-edge inputs and
// queues the outputs it expects after that edge; a monitor on the falling
// edge pops each entry and compares it with the DUT. Follows the
// RCM_GLITCH_FILTER_EN build option in the same way as the design.

`timescale 1ns/1ps

module tb_ripple_count_monitor;

  localparam int EXT_W = 4;
  localparam int CW    = EXT_W + 4;
  localparam int EXT_M = 1 << EXT_W;

  logic          clk = 1'b0;
  logic          rstb;
  logic [3:0]    q_in;
  logic          enable;
  logic          clr;
  logic [CW-1:0] thresh;
  logic          arm;
  logic          ack;
  logic [CW-1:0] count_ext;
  logic          wrap_pulse;
  logic          ovf;
  logic          match_irq;
  logic [1:0]    state;

  ripple_count_monitor #(.EXT_W(EXT_W)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .q_in       (q_in),
    .enable     (enable),
    .clr        (clr),
    .thresh     (thresh),
    .arm        (arm),
    .ack        (ack),
    .count_ext  (count_ext),
    .wrap_pulse (wrap_pulse),
    .ovf        (ovf),
    .match_irq  (match_irq),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int wp;
    int ovf;
    int irq;
    int st;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   wp_seen  = 0;

  // Reference model: samples seen at the last two edges (newest first),
  // accepted nibble, total wraps since the last clear, flags and FSM phase.
  int m_hist[2];
  int m_f;
  int m_wraps;
  int m_ovf;
  int m_wp;
  int m_st;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_hist[0] = 0;
    m_hist[1] = 0;
    m_f       = 0;
    m_wraps   = 0;
    m_ovf     = 0;
    m_wp      = 0;
    m_st      = 0;
  endtask

  // One rising edge of the model, using the inputs as they stand right now.
  task automatic model_edge();
    int   cnt;
    int   cand;
    bit   take;
    exp_t e;
    cnt  = (m_wraps % EXT_M) * 16 + m_f;
    cand = m_hist[0];
`ifdef RCM_GLITCH_FILTER_EN
    take = enable && (m_hist[0] == m_hist[1]);
`else
    take = enable;
`endif
    case (m_st)
      0: if (arm) m_st = 1;
      1: if (cnt >= int'(thresh)) m_st = 2;
      2: if (ack) m_st = 0;
      default: m_st = 0;
    endcase
    m_wp = 0;
    if (clr) begin
      m_wraps = 0;
      m_ovf   = 0;
    end else if (take && cand < m_f) begin
      m_wraps++;
      m_wp = 1;
      if (m_wraps % EXT_M == 0) m_ovf = 1;
    end
    if (take) m_f = cand;
    m_hist[1] = m_hist[0];
    m_hist[0] = int'(q_in);
    e.cnt = (m_wraps % EXT_M) * 16 + m_f;
    e.wp  = m_wp;
    e.ovf = m_ovf;
    e.irq = (m_st == 2) ? 1 : 0;
    e.st  = m_st;
    sb_q.push_back(e);
  endtask

  // Advance one clock: model and DUT see the same pre-edge inputs, then the
  // caller may change inputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hold(input int v, input int n);
    logic [31:0] vv;
    vv   = v;
    q_in = vv[3:0];
    repeat (n) tick();
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("count_ext",  int'(count_ext),  e.cnt);
        check("wrap_pulse", int'(wrap_pulse), e.wp);
        check("ovf",        int'(ovf),        e.ovf);
        check("match_irq",  int'(match_irq),  e.irq);
        check("state",      int'(state),      e.st);
        if (wrap_pulse) wp_seen++;
      end
    end
  end

  initial begin
    rstb   = 1'b0;
    q_in   = 4'd0;
    enable = 1'b1;
    clr    = 1'b0;
    thresh = '1;
    arm    = 1'b0;
    ack    = 1'b0;
    model_reset();

    // Reset state while rstb is held low.
    #1;
    check("rst_count_ext", int'(count_ext), 0);
    check("rst_state",     int'(state),     0);
    check("rst_flags",     int'({wrap_pulse, ovf, match_irq}), 0);
    #11 rstb = 1'b1;

    // Latency and single-cycle glitch.
    hold(0, 3);
    hold(5, 4);
    hold(9, 1);
    hold(5, 4);

    // Sixteen wraps from a cleared extension: ovf must set on the last one.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wp_seen = 0;
    for (int i = 0; i < 16; i++) begin
      hold(14, 3);
      hold(15, 3);
      hold(0, 3);
    end
    @(negedge clk);
    #1;
    check("wrap_count_16", wp_seen, 16);
    check("ovf_after_16",  int'(ovf), 1);
    check("ext_after_16",  int'(count_ext), 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();

    // Enable hold: f frozen while q_in moves, then catches up without a wrap.
    hold(3, 4);
    enable = 1'b0;
    hold(7, 4);
    enable = 1'b1;
    hold(7, 4);

    // Threshold crossing 0x11 -> 0x12, arm ignored in FIRED, then ack.
    thresh = 8'h12;
    hold(0, 3);
    hold(1, 3);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    hold(2, 4);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();

    // Count already past threshold when armed: one cycle ARMED, then FIRED.
    hold(15, 3);
    hold(0, 3);
    hold(15, 3);
    hold(0, 3);
    thresh = 8'h20;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // clr held across a 15 -> 0 step: clear wins over the wrap.
    hold(15, 3);
    clr = 1'b1;
    hold(0, 4);
    clr = 1'b0;
    tick();

    // Asynchronous reset while FIRED, between clock edges.
    thresh = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    hold(6, 3);
    @(negedge clk);
    #1;
    check("fired_before_rst", int'(state), 2);
    rstb = 1'b0;
    #1;
    check("arst_count_ext", int'(count_ext), 0);
    check("arst_state",     int'(state),     0);
    check("arst_flags",     int'({wrap_pulse, ovf, match_irq}), 0);
    sb_q.delete();
    model_reset();
    #1 rstb = 1'b1;
    hold(6, 4);

    // Randomized traffic.
    thresh = 8'h40;
    repeat (800) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) q_in = q_in + 4'd1;
      else if (r == 4) q_in = 4'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 59) == 0);
      arm    = ($urandom_range(0, 7) == 0);
      ack    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) thresh = CW'($urandom);
      tick();
    end
    enable = 1'b1;
    clr    = 1'b0;
    arm    = 1'b0;
    ack    = 1'b0;
    tick();

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
